// File: rtl/parking_scheduler.sv
// rtl/parking_scheduler.sv - eight-spot parking lot entry/exit scheduler with gate timing
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_entry_req         entry lane request (level, held until ack or error)
//   i_exit_req          exit lane request (level, held until ack or error)
//   i_exit_spot[2:0]    spot being vacated, valid with i_exit_req
//   o_entry_ack         one-cycle pulse: entry served
//   o_exit_ack          one-cycle pulse: exit served
//   o_spot_id[2:0]      spot allocated or freed by the last served request
//   o_gate_open         gate drive, high GATE_CYCLES cycles per served request
//   o_gate_sel          0 = entry gate, 1 = exit gate
//   o_occupancy[7:0]    spot map, bit i = spot i occupied
//   o_parked[3:0]       number of occupied spots
//   o_full, o_empty     occupancy all ones / all zeros
//   o_error             one-cycle pulse: request rejected
module parking_scheduler #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_entry_req,
    input  logic       i_exit_req,
    input  logic [2:0] i_exit_spot,
    output logic       o_entry_ack,
    output logic       o_exit_ack,
    output logic [2:0] o_spot_id,
    output logic       o_gate_open,
    output logic       o_gate_sel,
    output logic [7:0] o_occupancy,
    output logic [3:0] o_parked,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_EXIT,
        S_GATE,
        S_REJECT
    } state_t;

    // The counter is loaded in the ack cycle, so it counts the remaining cycles after it.
    localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

    state_t     r_state;
    logic       r_last_grant;   // 0 = entry served last, 1 = exit served last
    logic [2:0] r_exit_spot;
    logic [3:0] r_gate_cnt;
    logic [7:0] r_occupancy;
    logic [2:0] r_spot_id;
    logic       r_entry_ack;
    logic       r_exit_ack;
    logic       r_error;
    logic       r_gate_open;
    logic       r_gate_sel;

    logic [2:0] w_free_idx;
    logic [3:0] w_parked;
    logic       w_full;
    logic       w_grant_exit;

    // Lowest-index clear bit: scan from the top so the lowest match is written last.
    always_comb begin
        w_free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!r_occupancy[i]) begin
                w_free_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_parked = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_parked = w_parked + {3'b000, r_occupancy[i]};
        end
    end

    assign w_full = (r_occupancy == 8'hFF);

    // On a tie the lane that was not served last wins; the reset value favours exit.
    assign w_grant_exit = i_exit_req & (~i_entry_req | ~r_last_grant);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
            r_exit_spot  <= 3'd0;
            r_gate_cnt   <= 4'd0;
            r_occupancy  <= 8'h00;
            r_spot_id    <= 3'd0;
            r_entry_ack  <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_error      <= 1'b0;
            r_gate_open  <= 1'b0;
            r_gate_sel   <= 1'b0;
        end else begin
            r_entry_ack <= 1'b0;
            r_exit_ack  <= 1'b0;
            r_error     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_gate_open <= 1'b0;
                    if (i_entry_req || i_exit_req) begin
                        r_last_grant <= w_grant_exit;
                        if (w_grant_exit) begin
                            r_exit_spot <= i_exit_spot;
                            r_state     <= S_EXIT;
                        end else begin
                            r_state <= S_ENTRY;
                        end
                    end
                end
                S_ENTRY: begin
                    if (w_full) begin
                        r_error <= 1'b1;
                        r_state <= S_REJECT;
                    end else begin
                        r_occupancy[w_free_idx] <= 1'b1;
                        r_spot_id   <= w_free_idx;
                        r_entry_ack <= 1'b1;
                        r_gate_sel  <= 1'b0;
                        r_gate_open <= 1'b1;
                        r_gate_cnt  <= GATE_LOAD;
                        r_state     <= S_GATE;
                    end
                end
                S_EXIT: begin
                    if (!r_occupancy[r_exit_spot]) begin
                        r_error <= 1'b1;
                        r_state <= S_REJECT;
                    end else begin
                        r_occupancy[r_exit_spot] <= 1'b0;
                        r_spot_id   <= r_exit_spot;
                        r_exit_ack  <= 1'b1;
                        r_gate_sel  <= 1'b1;
                        r_gate_open <= 1'b1;
                        r_gate_cnt  <= GATE_LOAD;
                        r_state     <= S_GATE;
                    end
                end
                S_GATE: begin
                    if (r_gate_cnt == 4'd0) begin
                        r_gate_open <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt - 4'd1;
                    end
                end
                S_REJECT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_entry_ack = r_entry_ack;
    assign o_exit_ack  = r_exit_ack;
    assign o_spot_id   = r_spot_id;
    assign o_gate_open = r_gate_open;
    assign o_gate_sel  = r_gate_sel;
    assign o_occupancy = r_occupancy;
    assign o_parked    = w_parked;
    assign o_full      = w_full;
    assign o_empty     = (r_occupancy == 8'h00);
    assign o_error     = r_error;

endmodule

// File: doc/parking_scheduler.md
PARKING_SCHEDULER -- requirements
Module: parking_scheduler

Interface
REQ-001 Parameter: GATE_CYCLES, default 4, number of cycles gate_open stays high per served request; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 entry_req  input  1  level request from entry lane; held until entry_ack or error.
REQ-005 exit_req  input  1  level request from exit lane; held until exit_ack or error.
REQ-006 exit_spot  input  3  index of the spot being vacated; valid while exit_req is high.
REQ-007 entry_ack  output  1  one-cycle pulse: entry served.
REQ-008 exit_ack  output  1  one-cycle pulse: exit served.
REQ-009 spot_id  output  3  spot allocated (entry) or freed (exit); holds its value until the next served request.
REQ-010 gate_open  output  1  gate drive.
REQ-011 gate_sel  output  1  0 = entry gate, 1 = exit gate; valid while gate_open is high.
REQ-012 occupancy  output  8  registered spot map; bit i = spot i occupied.
REQ-013 parked  output  4  number of set bits in occupancy, range 0..8.
REQ-014 full  output  1  occupancy == 8'hFF.
REQ-015 empty  output  1  occupancy == 8'h00.
REQ-016 error  output  1  one-cycle pulse: request rejected.

Function
REQ-017 FSM states: IDLE, ENTRY, EXIT, GATE, REJECT.
REQ-018 IDLE arbitration:
  - Only entry_req high -> ENTRY.
  - Only exit_req high -> EXIT.
  - Both high -> grant the lane not served last (last_grant flag), then go to that lane's state.
  - Neither high -> stay in IDLE.
REQ-019 last_grant updates only on a grant; after reset, exit wins the first tie.
REQ-020 exit_spot is captured into an internal register on the edge that grants EXIT.
REQ-021 ENTRY, not full:
  - Set the lowest-index clear occupancy bit.
  - spot_id = that index.
  - entry_ack = 1 for one cycle.
  - gate_sel = 0; go to GATE.
  - All of the above take effect on the same edge.
REQ-022 ENTRY, full: occupancy unchanged, go to REJECT.
REQ-023 EXIT, captured spot occupied:
  - Clear that bit.
  - spot_id = captured index.
  - exit_ack = 1 for one cycle.
  - gate_sel = 1; go to GATE.
REQ-024 EXIT, captured spot already clear: occupancy unchanged, go to REJECT.
REQ-025 REJECT:
  - error = 1 for exactly that one cycle.
  - No ack, gate_open stays 0.
  - Next state IDLE; last_grant is still updated.
REQ-026 Latency: request sampled high in IDLE at edge N -> ack (or error) high in the cycle after edge N+1.
REQ-027 GATE:
  - gate_open = 1 for exactly GATE_CYCLES cycles, starting in the ack cycle.
  - A 4-bit down-counter times the interval.
  - Return to IDLE after the final cycle; gate_open = 0 in IDLE.
REQ-028 Requests are ignored outside IDLE. A request dropped before service is not remembered. A request still held after its ack is served again.
REQ-029 parked, full and empty are derived combinationally from the occupancy register, so they update in the same cycle as occupancy.
REQ-030 Occupancy is modified only in ENTRY/EXIT; at most one bit changes per served request.
REQ-031 Only a served entry raises parked; only a served exit lowers it. parked never goes above 8 or below 0.

Reset
REQ-032 reset high at a clock edge takes priority over every other event, including mid-GATE, mid-ENTRY and mid-EXIT.
REQ-033 Values after a reset edge:
  - state = IDLE, occupancy = 8'h00, parked = 0, empty = 1, full = 0.
  - entry_ack, exit_ack, error, gate_open, gate_sel = 0.
  - spot_id = 0, gate counter = 0, last_grant = entry.
REQ-034 A gate that was open closes in the first cycle after the reset edge; no ack or error is produced for an interrupted request.

Verification
REQ-035 Reset, then entry_req held -> entry_ack with spot_id=0; occupancy=8'h01, parked=1, empty=0; gate_open high 4 cycles with gate_sel=0.
REQ-036 Eight served entries -> occupancy=8'hFF, parked=8, full=1; ninth entry -> error pulse, no ack, gate_open stays 0, occupancy unchanged.
REQ-037 From 8'hFF, exit with exit_spot=3 -> exit_ack, spot_id=3, occupancy=8'hF7, parked=7; next entry -> spot_id=3, occupancy=8'hFF.
REQ-038 entry_req and exit_req (exit_spot=0, spot 0 occupied) both held after reset -> exit served first, then entry; entry gets spot_id=0; grants alternate while both stay held.
REQ-039 From empty, exit with exit_spot=5 -> error pulse, occupancy=8'h00, parked=0, no gate activity.
REQ-040 reset asserted in the 2nd GATE cycle with occupancy=8'h07 -> next cycle gate_open=0, occupancy=8'h00, parked=0, state IDLE.
